sequential_restoring_divider: RTL and testbench

Multi-cycle unsigned integer divider. It is the inverse of the team's array-multiplier datapath: quotient = dividend / divisor, remainder = dividend mod divisor.
- Algorithm: restoring shift-subtract, one quotient bit per clock.
- Interface: start/busy/done handshake.
- Use: feeds arithmetic results back to the top level alongside the combinational multiplier.

---
 rtl/sequential_restoring_divider_pkg.sv | 25 ++
 rtl/sequential_restoring_divider_if.sv | 37 +++
 rtl/sequential_restoring_divider_step.sv | 35 +++
 rtl/sequential_restoring_divider.sv | 167 ++++++++++++++++
 tb/tb_sequential_restoring_divider.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/sequential_restoring_divider_pkg.sv
// ----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider slice:
//   - state_e       : controller states (IDLE, RUN, FINISH, FIXUP)
//   - cnt_width()   : width of the step counter, clog2(WIDTH+1)
//   - DBZ_QUOTIENT  : quotient returned on divide-by-zero (all ones);
//                     users slice the low WIDTH bits
// FIXUP is only reachable when DIVIDER_SIGNED_EN is defined.
// ----------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        FIXUP  = 2'd3
    } state_e;

    localparam logic [31:0] DBZ_QUOTIENT = '1;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sequential_restoring_divider_if.sv
// ----------------------------------------------------------------------------
// sequential_restoring_divider_if
// Start/busy/done handshake bundle for the divider.
//   master : drives start, dividend, divisor; observes results
//   slave  : the divider itself
// Signals:
//   start      request a division (sampled only when not busy)
//   dividend   numerator, WIDTH bits
//   divisor    denominator, WIDTH bits
//   busy       operation in progress
//   done       one-cycle pulse, results valid
//   quotient   result quotient, WIDTH bits
//   remainder  result remainder, WIDTH bits
//   divByZero  divisor was zero for the last result
// ----------------------------------------------------------------------------
interface sequential_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, divByZero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, divByZero
    );
endinterface

// File: rtl/sequential_restoring_divider_step.sv
// ----------------------------------------------------------------------------
// divider_step
// Combinational single trial-subtract cell of a restoring divider.
// Ports:
//   partial_in   current partial remainder (WIDTH+1 bits)
//   bit_in       next dividend bit, shifted in at the LSB
//   divisor      divisor magnitude (WIDTH bits)
//   partial_out  next partial remainder (WIDTH+1 bits)
//   quot_bit     quotient bit produced by this step
// ----------------------------------------------------------------------------
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   partial_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   partial_out,
    output logic             quot_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The shifted value is always below 2^(WIDTH+1), so one extra bit of
    // headroom makes the MSB of the difference a reliable borrow flag.
    always_comb begin
        shifted     = {partial_in, bit_in};
        diff        = shifted - {2'b00, divisor};
        quot_bit    = ~diff[WIDTH+1];
        partial_out = quot_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/sequential_restoring_divider.sv
// ----------------------------------------------------------------------------
// sequential_restoring_divider
// Multi-cycle unsigned divider, one quotient bit per clock (restoring
// shift-subtract, MSB first). Latency from accepted start to done is
// WIDTH+1 cycles; divide-by-zero finishes in one cycle with quotient all
// ones, remainder = dividend and divByZero set.
// Optional macro DIVIDER_SIGNED_EN: two's-complement operands, magnitudes
// divided by the same core, sign fixed in an extra FIXUP cycle (latency
// WIDTH+2). Quotient truncates toward zero, remainder follows the dividend.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    sequential_restoring_divider_if.slave handshake/results
// ----------------------------------------------------------------------------
module sequential_restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    sequential_restoring_divider_if.slave bus
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   partial_q, partial_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
`ifdef DIVIDER_SIGNED_EN
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
`endif

    logic [WIDTH:0]   step_partial;
    logic             step_bit;
    logic [WIDTH-1:0] step_shift;

    // shift_q starts as the dividend; its MSB feeds each step and the
    // quotient bits fill in from the LSB, so after WIDTH steps it holds
    // the quotient.
    divider_step #(.WIDTH(WIDTH)) u_step (
        .partial_in  (partial_q),
        .bit_in      (shift_q[WIDTH-1]),
        .divisor     (divisor_q),
        .partial_out (step_partial),
        .quot_bit    (step_bit)
    );

    assign step_shift = {shift_q[WIDTH-2:0], step_bit};

    // Next-state and datapath control. Outputs hold by default and only
    // change on a divide-by-zero start or at the end of the computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        partial_d     = partial_q;
        shift_d       = shift_q;
        divisor_d     = divisor_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
`ifdef DIVIDER_SIGNED_EN
        quot_neg_d    = quot_neg_q;
        rem_neg_d     = rem_neg_q;
`endif
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (bus.start) begin
                    cnt_d         = '0;
                    partial_d     = '0;
                    div_by_zero_d = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    shift_d    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                    divisor_d  = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
                    quot_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    rem_neg_d  = bus.dividend[WIDTH-1];
`else
                    shift_d    = bus.dividend;
                    divisor_d  = bus.divisor;
`endif
                    if (bus.divisor == '0) begin
                        state_d       = FINISH;
                        quotient_d    = DBZ_QUOTIENT[WIDTH-1:0];
                        remainder_d   = bus.dividend;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                partial_d = step_partial;
                shift_d   = step_shift;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
`ifdef DIVIDER_SIGNED_EN
                    state_d     = FIXUP;
`else
                    state_d     = FINISH;
                    quotient_d  = step_shift;
                    remainder_d = step_partial[WIDTH-1:0];
`endif
                end
            end
`ifdef DIVIDER_SIGNED_EN
            // Magnitude results sit in shift_q/partial_q; apply the signs.
            // Most-negative / -1 naturally yields the most-negative value.
            FIXUP: begin
                state_d     = FINISH;
                quotient_d  = quot_neg_q ? -shift_q : shift_q;
                remainder_d = rem_neg_q ? -partial_q[WIDTH-1:0] : partial_q[WIDTH-1:0];
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            partial_q     <= '0;
            shift_q       <= '0;
            divisor_q     <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            quot_neg_q    <= 1'b0;
            rem_neg_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            partial_q     <= partial_d;
            shift_q       <= shift_d;
            divisor_q     <= divisor_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
`ifdef DIVIDER_SIGNED_EN
            quot_neg_q    <= quot_neg_d;
            rem_neg_q     <= rem_neg_d;
`endif
        end
    end

`ifdef DIVIDER_SIGNED_EN
    assign bus.busy = (state_q == RUN) || (state_q == FIXUP);
`else
    assign bus.busy = (state_q == RUN);
`endif
    assign bus.done      = (state_q == FINISH);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.divByZero = div_by_zero_q;

endmodule

// File: tb/tb_sequential_restoring_divider.sv
// ----------------------------------------------------------------------------
// tb_sequential_restoring_divider
// Directed self-checking bench for sequential_restoring_divider (WIDTH=8).
// Inputs change and outputs are sampled on the falling clock edge. Cycle
// numbers are counted from the accepting rising edge (cycle 1 = first cycle
// after it). Define DIVIDER_SIGNED_EN to run the signed vectors instead of
// the unsigned ones.
// ----------------------------------------------------------------------------
module tb_sequential_restoring_divider;

    localparam int WIDTH = 8;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sequential_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    sequential_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents one start pulse; returns at the falling edge of cycle 1.
    task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
        @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clock);
        bus.start    = 1'b0;
    endtask

    // Bounded wait for done starting at cycle firstCycle; -1 means timeout.
    task automatic waitDone(input int firstCycle, output int doneCycle, output int busyCount);
        doneCycle = -1;
        busyCount = 0;
        for (int c = firstCycle; c < firstCycle + 40; c++) begin
            if (bus.done === 1'b1) begin
                doneCycle = c;
                break;
            end
            if (bus.busy === 1'b1) busyCount++;
            @(negedge clock);
        end
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] q,
                               input logic [WIDTH-1:0] r, input logic dbz);
        checkOutput({tag, " quotient"}, 32'(bus.quotient), 32'(q));
        checkOutput({tag, " remainder"}, 32'(bus.remainder), 32'(r));
        checkOutput({tag, " divByZero"}, 32'(bus.divByZero), 32'(dbz));
    endtask

    task automatic runDivision(input string tag, input logic [WIDTH-1:0] dvd,
                               input logic [WIDTH-1:0] dvs, input int expDone,
                               input int expBusy, input logic [WIDTH-1:0] q,
                               input logic [WIDTH-1:0] r, input logic dbz);
        int dc;
        int bc;
        applyStimulus(dvd, dvs);
        waitDone(1, dc, bc);
        checkOutput({tag, " done cycle"}, 32'(dc), 32'(expDone));
        if (expBusy >= 0) checkOutput({tag, " busy cycles"}, 32'(bc), 32'(expBusy));
        checkResult(tag, q, r, dbz);
    endtask

    initial begin
        int dc;
        int bc;
        logic sawDone;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkResult("reset", 8'd0, 8'd0, 1'b0);
        reset = 1'b0;

`ifndef DIVIDER_SIGNED_EN
        runDivision("200/7", 8'd200, 8'd7, 9, 8, 8'd28, 8'd4, 1'b0);
        @(negedge clock);
        checkOutput("done single pulse", 32'(bus.done), 32'd0);

        runDivision("5/9", 8'd5, 8'd9, 9, 8, 8'd0, 8'd5, 1'b0);
        runDivision("255/1", 8'd255, 8'd1, 9, 8, 8'd255, 8'd0, 1'b0);

        runDivision("100/0", 8'd100, 8'd0, 1, 0, 8'hFF, 8'd100, 1'b1);
        runDivision("6/3", 8'd6, 8'd3, 9, 8, 8'd2, 8'd0, 1'b0);

        // Start pulse during busy cycle 4 must be ignored.
        applyStimulus(8'd200, 8'd7);
        repeat (3) @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(negedge clock);
        bus.start    = 1'b0;
        waitDone(5, dc, bc);
        checkOutput("ignored start done cycle", 32'(dc), 32'd9);
        checkResult("ignored start", 8'd28, 8'd4, 1'b0);

        // Start presented in the FINISH cycle is accepted with no gap.
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(negedge clock);
        bus.start    = 1'b0;
        waitDone(1, dc, bc);
        checkOutput("back-to-back done cycle", 32'(dc), 32'd9);
        checkResult("back-to-back 9/3", 8'd3, 8'd0, 1'b0);

        // Reset during busy cycle 5 discards the operation.
        applyStimulus(8'd200, 8'd7);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid-run reset busy", 32'(bus.busy), 32'd0);
        checkOutput("mid-run reset done", 32'(bus.done), 32'd0);
        checkResult("mid-run reset", 8'd0, 8'd0, 1'b0);
        sawDone = 1'b0;
        repeat (12) begin
            if (bus.done !== 1'b0) sawDone = 1'b1;
            @(negedge clock);
        end
        checkOutput("no done after reset", 32'(sawDone), 32'd0);
        runDivision("123/10 after reset", 8'd123, 8'd10, 9, 8, 8'd12, 8'd3, 1'b0);
`else
        runDivision("-7/2", 8'hF9, 8'd2, 10, -1, 8'hFD, 8'hFF, 1'b0);
        runDivision("-128/-1", 8'h80, 8'hFF, 10, -1, 8'h80, 8'h00, 1'b0);
        runDivision("-5/0", 8'hFB, 8'h00, 1, 0, 8'hFF, 8'hFB, 1'b1);
        runDivision("7/-2", 8'd7, 8'hFE, 10, -1, 8'hFD, 8'h01, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
